// File: rtl/lut_scan_seq_if.sv
// Lookup/write/scan bus for lut_scan_seq.
// master drives requests, slave returns registered results.
interface lut_scan_seq_if #(
    parameter int W_IN  = 3,
    parameter int W_OUT = 2
);
    logic             we;
    logic [W_IN-1:0]  waddr;
    logic [W_OUT-1:0] wdata;
    logic             i_valid;
    logic [W_IN-1:0]  i;
    logic             scan_start;
    logic             o_valid;
    logic [W_OUT-1:0] o;
    logic [W_IN-1:0]  o_addr;
    logic             busy;
    logic             scan_done;

    modport master (
        output we, waddr, wdata, i_valid, i, scan_start,
        input  o_valid, o, o_addr, busy, scan_done
    );

    modport slave (
        input  we, waddr, wdata, i_valid, i, scan_start,
        output o_valid, o, o_addr, busy, scan_done
    );
endinterface

// File: rtl/lut_scan_seq.sv
// Registered programmable truth table with single lookups
// and an autonomous full-table scan.
module lut_scan_seq #(
    parameter int W_IN  = 3,
    parameter int W_OUT = 2,
    parameter logic [(2**W_IN)*W_OUT-1:0] INIT = 16'h0F37
) (
    input  logic          clk,
    input  logic          rst_b,
    lut_scan_seq_if.slave bus
);
    localparam int DEPTH = 2**W_IN;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t           state, state_d;
    logic [W_IN-1:0]  cnt, cnt_d;
    logic [W_IN-1:0]  ra;
    logic [W_OUT-1:0] tbl [DEPTH];
    logic [W_OUT-1:0] rdata;
    logic             ld, done_d;
    logic             o_valid_q, done_q;
    logic [W_OUT-1:0] o_q;
    logic [W_IN-1:0]  o_addr_q;

    // write-first bypass for a same-edge write to the read address
    assign rdata = (bus.we && bus.waddr == ra) ? bus.wdata : tbl[ra];

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        ra      = bus.i;
        ld      = 1'b0;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.scan_start) begin
                    ra    = cnt;
                    ld    = 1'b1;
                    cnt_d = cnt + W_IN'(1);
                    if (&cnt) done_d  = 1'b1;
                    else      state_d = SCAN;
                end else if (bus.i_valid) begin
                    ld = 1'b1;
                end
            end
            SCAN: begin
                ra    = cnt;
                ld    = 1'b1;
                cnt_d = cnt + W_IN'(1);
                if (&cnt) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            o_valid_q <= 1'b0;
            done_q    <= 1'b0;
            o_q       <= '0;
            o_addr_q  <= '0;
        end else begin
            o_valid_q <= ld;
            done_q    <= done_d;
            if (ld) begin
                o_q      <= rdata;
                o_addr_q <= ra;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < DEPTH; k++)
                tbl[k] <= INIT[k*W_OUT +: W_OUT];
        end else if (bus.we) begin
            tbl[bus.waddr] <= bus.wdata;
        end
    end

    assign bus.o_valid   = o_valid_q;
    assign bus.o         = o_q;
    assign bus.o_addr    = o_addr_q;
    assign bus.busy      = (state == SCAN);
    assign bus.scan_done = done_q;
endmodule

// File: doc/lut_scan_seq.md
Name: lut_scan_seq

Overview:
- Registered, run-time programmable truth-table unit. Maps a W_IN-bit code to a W_OUT-bit code.
- The table resets to a parameter-defined contents and can be rewritten entry by entry.
- Supports single lookups with a valid handshake.
- Has an autonomous scan mode that streams every entry in address order, for self-check and table dump.
- Sits between the input decode logic and downstream consumers that need a registered, reconfigurable mapping.

Parameters:
- W_IN, 3, address/input code width; table depth = 2**W_IN.
- W_OUT, 2, entry/output code width.
- INIT, 16'h0F37, reset contents, (2**W_IN)*W_OUT bits; entry k = INIT[k*W_OUT +: W_OUT]. Default gives entries 0..7 = 11,01,11,00,11,11,00,00.

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous, active-low reset
- we  in  1  table write enable
- waddr  in  W_IN  write address
- wdata  in  W_OUT  write data
- i_valid  in  1  lookup request
- i  in  W_IN  lookup address
- scan_start  in  1  start scan of whole table
- o_valid  out  1  o/o_addr hold a valid result this cycle
- o  out  W_OUT  looked-up entry
- o_addr  out  W_IN  address that produced o
- busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse with last scanned entry

Behaviour:
- Reset (rst_b=0, asynchronous, any time including mid-scan):
  - table <= INIT; state IDLE; internal scan counter 0.
  - o_valid=0, o=0, o_addr=0, busy=0, scan_done=0.
- States:
  - IDLE -> SCAN when scan_start=1.
  - SCAN -> IDLE on the edge that outputs address 2**W_IN-1.
  - busy = (state==SCAN).
- Write:
  - we=1 updates table[waddr] at the rising edge. Accepted in any state.
- Lookup (IDLE only):
  - i_valid=1 in cycle n gives o=table[i], o_addr=i, o_valid=1 in cycle n+1 (1-cycle latency).
  - o_valid=0 in any cycle not carrying a result.
  - o and o_addr hold their last value when o_valid=0.
- Read-during-write, same address, same edge: write-first. o returns wdata. Applies to lookup and scan.
- Scan start:
  - scan_start=1 in IDLE at cycle n: entry 0 is output in cycle n+1 (o_valid=1, o_addr=0).
  - Each following cycle outputs the next address.
  - Address 2**W_IN-1 is output in cycle n+2**W_IN, with scan_done=1 in that same cycle only.
- State timing during scan:
  - busy=1 in cycles n+1 .. n+2**W_IN-1.
  - busy=0 in the cycle the last entry is shown, so a lookup can be issued back-to-back with no gap.
- Simultaneous scan_start and i_valid in IDLE: scan wins, lookup dropped (no result produced).
- i_valid and scan_start while busy=1: ignored, no effect.
- Scan counter wraps to 0 after the last address; it is not visible externally.
- No backpressure: results are valid for exactly one cycle.

Test Plan:
1. Reset then lookups i=0..7, one per cycle, i_valid=1 -> o sequence 11,01,11,00,11,11,00,00, each one cycle after its request; o_addr matches i.
2. we=1, waddr=3, wdata=10, then lookup i=3 -> o=10. Lookup i=2 -> o=11 (unchanged).
3. Same-cycle we=1, waddr=5, wdata=01 with i_valid=1, i=5 -> next cycle o=01 (write-first).
4. scan_start pulse at cycle n -> o_valid=1 in cycles n+1..n+8, o_addr 0..7, o = table contents. busy=1 in n+1..n+7. scan_done=1 only in n+8. i_valid asserted at n+3 -> no extra result.
5. scan_start and i_valid=1 (i=6) in the same cycle -> scan output only; no result for i=6.
6. rst_b=0 at cycle n+4 of a scan after writing entry 0=00 -> immediately o_valid=0, busy=0, scan_done=0. After release, lookup i=0 -> o=11 (INIT restored).
